// File: rtl/jdrosent_pulse_train_gen.sv
// Burst generator: a rising edge on start emits count+1 square pulses with equal
// high/low phase widths of 1, 2, 4 or 8 cycles, then a one-cycle done strobe.
module jdrosent_pulse_train_gen (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HIGH = 2'b01,
    S_LOW  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  logic       w_clk;
  logic       w_rst;
  logic       w_start;
  logic [2:0] w_count_in;
  logic [1:0] w_wsel_in;

  assign w_clk      = io_in[0];
  assign w_rst      = io_in[1];
  assign w_start    = io_in[2];
  assign w_count_in = io_in[5:3];
  assign w_wsel_in  = io_in[7:6];

  state_t     r_state;
  logic       r_start_q;
  logic [2:0] r_count;
  logic [1:0] r_wsel;
  logic [2:0] r_phase;
  logic [2:0] r_idx;

  logic       w_start_edge;
  logic [2:0] w_phase_max;
  logic       w_phase_last;

  assign w_start_edge = w_start & ~r_start_q;
  // Terminal phase count W-1 for W = 1, 2, 4, 8.
  assign w_phase_max  = {(r_wsel == 2'b11), r_wsel[1], |r_wsel};
  assign w_phase_last = (r_phase == w_phase_max);

  // The edge detector keeps sampling through reset so a start held high
  // across reset release is not mistaken for a fresh request.
  always_ff @(posedge w_clk) begin
    r_start_q <= w_start;
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state <= S_IDLE;
      r_count <= 3'd0;
      r_wsel  <= 2'd0;
      r_phase <= 3'd0;
      r_idx   <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_count <= w_count_in;
            r_wsel  <= w_wsel_in;
            r_phase <= 3'd0;
            r_idx   <= 3'd0;
            r_state <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (w_phase_last) begin
            r_phase <= 3'd0;
            r_state <= S_LOW;
          end else begin
            r_phase <= r_phase + 3'd1;
          end
        end
        S_LOW: begin
          if (w_phase_last) begin
            r_phase <= 3'd0;
            if (r_idx == r_count) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= S_HIGH;
            end
          end else begin
            r_phase <= r_phase + 3'd1;
          end
        end
        default: begin
          r_idx   <= 3'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are a pure decode of registered state; io_in never reaches io_out.
  assign io_out[0]   = (r_state == S_HIGH);
  assign io_out[1]   = (r_state == S_HIGH) || (r_state == S_LOW);
  assign io_out[2]   = (r_state == S_DONE);
  assign io_out[5:3] = r_idx;
  assign io_out[7:6] = r_state;

endmodule

// File: doc/jdrosent_pulse_train_gen.md
# jdrosent_pulse_train_gen

Edge-generating counterpart of the rising edge detector: on a rising edge of its start input, the block transmits a burst of 1 to 8 clean rising edges on a single output pin. The burst has programmable, equal high and low phase widths. It occupies one 8-bit TinyTapeout user slot. It is the stimulus source the team pairs with edge-detect logic on the bench and on silicon.

## Interface
Parameters:
- none; all configuration arrives on io_in and is latched at burst start.

Ports:
- io_in[0]  input  1  clock; every flop is clocked on its rising edge.
- io_in[1]  input  1  reset; synchronous, active-high.
- io_in[2]  input  1  start; a 0→1 transition, detected internally, requests a burst.
- io_in[5:3]  input  3  count; the burst has count+1 pulses (1..8).
- io_in[7:6]  input  2  width select; phase width W = 1, 2, 4 or 8 cycles for 00, 01, 10, 11.
- io_out[0]  output  1  pulse_out; the generated pulse train.
- io_out[1]  output  1  busy; high while in the HIGH or LOW state.
- io_out[2]  output  1  done; one-cycle strobe after the final low phase.
- io_out[5:3]  output  3  pulse index; 0-based index of the current pulse, 0 when idle.
- io_out[7:6]  output  2  state code; IDLE=00, HIGH=01, LOW=10, DONE=11.

## Operation
- Start edge detection:
  - start_q samples io_in[2] every cycle, including during reset.
  - start_edge = io_in[2] & ~start_q.
- State machine, with states IDLE, HIGH, LOW and DONE:
  - IDLE:
    - On start_edge, latch count (3 bits) and W, clear the phase counter and the pulse index, and go to HIGH.
    - Otherwise stay in IDLE.
  - HIGH: pulse_out=1. After W cycles in HIGH, go to LOW.
  - LOW: pulse_out=0. After W cycles in LOW:
    - If pulse index == latched count, go to DONE.
    - Otherwise increment the pulse index and go to HIGH.
  - DONE: done=1 for exactly one cycle, then go to IDLE with the pulse index cleared.
- The phase counter is 3 bits; it counts 0..W-1 and wraps to 0 on every phase change.
- start_edge is acted on only in IDLE. Edges arriving in HIGH, LOW or DONE are discarded, not queued.
- Changes on io_in[7:3] have no effect on a burst already in progress.
- All outputs are registered and decoded from state, the pulse index and the phase counter only. No combinational path exists from io_in to io_out.
- Reset:
  - Forces IDLE, clears the phase counter, the pulse index and the latched configuration.
  - A start input held high through reset release produces no burst, because start_q tracks it during reset.

## Timing
- Reset values: io_out = 8'h00 (pulse_out=0, busy=0, done=0, index=0, state=00).
- Start latency: start_edge sampled at clock edge k gives pulse_out=1 and busy=1 from edge k onward, i.e. visible in the cycle after edge k.
- Each pulse is exactly W cycles high followed by W cycles low.
- Burst length: busy stays high for 2·W·(count+1) cycles.
  - done is high in the cycle immediately after busy falls.
  - The block is back in IDLE the cycle after that.
- Re-trigger: the earliest accepted new start_edge is in the first IDLE cycle. This requires start to go low and return high.
- Reset mid-burst: at the first edge with reset=1, pulse_out drops to 0 and the state becomes IDLE. No done strobe is issued.

## Test plan
- Reset: hold io_in[1]=1 for 2 cycles with random io_in[7:2] -> io_out == 8'h00 throughout and after release.
- Minimal burst (count=0, width=00): start 0→1 -> pulse_out sequence 1,0, busy high 2 cycles, then done=1 for 1 cycle, state 01,10,11,00.
- Maximal burst (count=7, width=11): start edge -> 8 pulses, each 8 cycles high and 8 low. busy high for 128 cycles, index steps 0..7, done in cycle 129.
- Ignored inputs: during a count=3/width=01 burst, toggle start and set count=7/width=11 -> exactly 4 pulses of width 2, and no second burst.
- Reset mid-burst: assert reset in the 3rd HIGH phase while holding start=1 -> pulse_out=0 the next cycle, done never asserts, and no burst starts after reset release.
- Held start: hold start=1 past done -> a single burst only. Dropping start then raising it again -> a new burst with latency 1.
